// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - request/response/flush bundle between two requesters and the shared multiplier arbiter
interface mul_share_arbiter_if #(
    parameter int W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0][2:0]     req_funct3;
    logic [1:0][W-1:0]   req_a;
    logic [1:0][W-1:0]   req_b;
    logic [1:0]          flush;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [W-1:0]        resp_result;

    modport master (
        output req_valid, req_funct3, req_a, req_b, flush, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_funct3, req_a, req_b, flush, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one pipelined multiplier between two requesters
module mul_share_arbiter #(
    parameter int LATENCY = 4,
    parameter int W       = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mul_share_arbiter_if.slave   bus,
    output logic                 mul_ce,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_p_ss,
    input  logic [W-1:0]         mul_p_su,
    input  logic [W-1:0]         mul_p_uu,
    output logic                 idle
);
    localparam int L = LATENCY;

    // Tag pipe: one {valid, owner, funct3} entry per multiplier stage.
    logic [L-1:0]      tag_v_q,  tag_v_d;
    logic [L-1:0]      tag_id_q, tag_id_d;
    logic [L-1:0][2:0] tag_f3_q, tag_f3_d;

    logic              rr_ptr_q, rr_ptr_d;
    logic [W-1:0]      mul_a_q, mul_a_d;
    logic [W-1:0]      mul_b_q, mul_b_d;

    logic              retire_v;
    logic              retire_id;
    logic [2:0]        retire_f3;
    logic              stall;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              win_id;

    // Stall / clock-enable and round-robin arbitration.
    always_comb begin
        retire_v  = tag_v_q[L-1];
        retire_id = tag_id_q[L-1];
        retire_f3 = tag_f3_q[L-1];
        // A retiring op being flushed is dropped, so it must not hold the pipe.
        stall     = retire_v && !bus.resp_ready[retire_id] && !bus.flush[retire_id];
        mul_ce    = reset_n && !stall;
        eligible  = bus.req_valid & ~bus.flush & {2{mul_ce}};
        grant     = 2'b00;
        win_id    = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        case (eligible)
            2'b01: begin
                grant  = 2'b01;
                win_id = 1'b0;
            end
            2'b10: begin
                grant  = 2'b10;
                win_id = 1'b1;
            end
            2'b11: begin
                grant[rr_ptr_q] = 1'b1;
                win_id          = rr_ptr_q;
                rr_ptr_d        = ~rr_ptr_q;
            end
            default: ;
        endcase
    end

    // Tag pipe advance, operand capture and flush masking.
    always_comb begin
        tag_v_d  = tag_v_q;
        tag_id_d = tag_id_q;
        tag_f3_d = tag_f3_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        if (mul_ce) begin
            tag_v_d[0]  = |grant;
            tag_id_d[0] = win_id;
            tag_f3_d[0] = bus.req_funct3[win_id];
            for (int k = 1; k < L; k++) begin
                tag_v_d[k]  = tag_v_q[k-1];
                tag_id_d[k] = tag_id_q[k-1];
                tag_f3_d[k] = tag_f3_q[k-1];
            end
            if (|grant) begin
                mul_a_d = bus.req_a[win_id];
                mul_b_d = bus.req_b[win_id];
            end
        end
        // Flush applies to whatever the stages hold after this edge, stalled or not.
        for (int k = 0; k < L; k++) begin
            if (bus.flush[tag_id_d[k]]) begin
                tag_v_d[k] = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
            tag_f3_q <= '0;
            rr_ptr_q <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            tag_f3_q <= tag_f3_d;
            rr_ptr_q <= rr_ptr_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
        end
    end

    // Response routing and funct3 result select at the retire stage.
    always_comb begin
        bus.req_ready     = grant;
        bus.resp_valid[0] = reset_n && retire_v && !retire_id;
        bus.resp_valid[1] = reset_n && retire_v &&  retire_id;
        case (retire_f3)
            3'b000:  bus.resp_result = mul_p_ss[W-1:0];
            3'b001:  bus.resp_result = mul_p_ss[2*W-1:W];
            3'b010:  bus.resp_result = mul_p_su;
            3'b011:  bus.resp_result = mul_p_uu;
            default: bus.resp_result = '0;
        endcase
        mul_a = mul_a_q;
        mul_b = mul_b_q;
        idle  = !reset_n || !(|tag_v_q);
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench for mul_share_arbiter
module tb_mul_share_arbiter;
    localparam int L = 4;
    localparam int W = 32;

    logic          clk;
    logic          reset_n;
    logic          mul_ce;
    logic [W-1:0]  mul_a, mul_b;
    logic [2*W-1:0] mul_p_ss;
    logic [W-1:0]  mul_p_su, mul_p_uu;
    logic          idle;

    mul_share_arbiter_if #(.W(W)) bus ();

    mul_share_arbiter #(.LATENCY(L), .W(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .mul_ce   (mul_ce),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p_ss (mul_p_ss),
        .mul_p_su (mul_p_su),
        .mul_p_uu (mul_p_uu),
        .idle     (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier datapath model: L-1 enabled registers after the operand register.
    logic [W-1:0] pa [0:L-2];
    logic [W-1:0] pb [0:L-2];
    logic [63:0]  p_ss_w, p_su_w, p_uu_w;
    always @(posedge clk) begin
        if (mul_ce) begin
            pa[0] <= mul_a;
            pb[0] <= mul_b;
            for (int k = 1; k < L-1; k++) begin
                pa[k] <= pa[k-1];
                pb[k] <= pb[k-1];
            end
        end
    end
    assign p_ss_w   = {{32{pa[L-2][31]}}, pa[L-2]} * {{32{pb[L-2][31]}}, pb[L-2]};
    assign p_su_w   = {{32{pa[L-2][31]}}, pa[L-2]} * {32'b0, pb[L-2]};
    assign p_uu_w   = {32'b0, pa[L-2]} * {32'b0, pb[L-2]};
    assign mul_p_ss = p_ss_w;
    assign mul_p_su = p_su_w[63:32];
    assign mul_p_uu = p_uu_w[63:32];

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'b000: begin p = sa * sb;           return p[31:0];  end
            3'b001: begin p = sa * sb;           return p[63:32]; end
            3'b010: begin p = sa * longint'(ub); return p[63:32]; end
            3'b011: begin p = ua * ub;           return p[63:32]; end
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard: push on accept, pop on delivered response, drop on flush.
    always @(negedge clk) begin
        if (!reset_n) begin
            q0.delete();
            q1.delete();
        end else begin
            check("rdy_onehot", 64'($countones(bus.req_ready) <= 1), 64'(1));
            for (int i = 0; i < 2; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    if (i == 0) q0.push_back(exp_res(bus.req_a[i], bus.req_b[i], bus.req_funct3[i]));
                    else        q1.push_back(exp_res(bus.req_a[i], bus.req_b[i], bus.req_funct3[i]));
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (bus.resp_valid[i] && bus.resp_ready[i] && !bus.flush[i]) begin
                    if (i == 0) begin
                        if (q0.size() == 0) check("unexp_resp0", 64'(1), 64'(0));
                        else check("resp0", 64'(bus.resp_result), 64'(q0.pop_front()));
                    end else begin
                        if (q1.size() == 0) check("unexp_resp1", 64'(1), 64'(0));
                        else check("resp1", 64'(bus.resp_result), 64'(q1.pop_front()));
                    end
                end
            end
            if (bus.flush[0]) q0.delete();
            if (bus.flush[1]) q1.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
        bus.req_valid[port]  = 1'b1;
        bus.req_a[port]      = a;
        bus.req_b[port]      = b;
        bus.req_funct3[port] = f3;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !idle) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n < 60), 64'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got[$];
        logic [31:0] r0;
        logic [31:0] spec_exp [4];
        reset_n         = 1'b0;
        bus.req_valid   = 2'b11;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_funct3  = '0;
        bus.flush       = 2'b00;
        bus.resp_ready  = 2'b11;

        // Reset behaviour with requests pending.
        repeat (3) step();
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_mul_ce", 64'(mul_ce), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_mul_a", 64'(mul_a), 64'(0));
        step();
        reset_n       = 1'b1;
        bus.req_valid = 2'b00;

        // Single MUL on port 0: result four cycles after acceptance.
        step();
        drive(0, 32'd7, 32'hFFFF_FFFD, 3'b000);
        @(negedge clk);
        check("single_accept", 64'(bus.req_ready), 64'(2'b01));
        step();
        bus.req_valid = 2'b00;
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            if (k < L) check("single_early", 64'(bus.resp_valid), 64'(0));
            else begin
                check("single_valid", 64'(bus.resp_valid), 64'(2'b01));
                check("single_result", 64'(bus.resp_result), 64'(32'hFFFF_FFEB));
            end
        end
        @(negedge clk);
        check("single_idle", 64'(idle), 64'(1));

        // Contention: alternate grants starting with port 0.
        for (int k = 0; k < 6; k++) begin
            step();
            drive(0, $urandom, $urandom, 3'($urandom_range(0, 7)));
            drive(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
            @(negedge clk);
            check("rr_grant", 64'(bus.req_ready), 64'((k % 2) ? 2'b10 : 2'b01));
        end
        step();
        bus.req_valid = 2'b00;
        drain();

        // High-word variants and an unsupported funct3.
        spec_exp = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        step(); drive(0, 32'h8000_0000, 32'hFFFF_FFFF, 3'b001);
        step(); drive(0, 32'h8000_0000, 32'hFFFF_FFFF, 3'b011);
        step(); drive(0, 32'h8000_0000, 32'hFFFF_FFFF, 3'b010);
        step(); drive(0, 32'h8000_0000, 32'hFFFF_FFFF, 3'b101);
        step();
        bus.req_valid = 2'b00;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.resp_valid[0]) got.push_back(bus.resp_result);
        end
        check("hi_count", 64'(got.size()), 64'(4));
        for (int k = 0; k < 4 && k < got.size(); k++) check("hi_result", 64'(got[k]), 64'(spec_exp[k]));
        drain();

        // Back-pressure on port 1 for three retire cycles.
        step();
        drive(1, 32'h0001_2345, 32'h0000_0100, 3'b000);
        bus.resp_ready = 2'b01;
        @(negedge clk);
        check("bp_accept", 64'(bus.req_ready), 64'(2'b10));
        step();
        bus.req_valid = 2'b00;
        step();
        step();
        drive(0, 32'd11, 32'd13, 3'b000);
        @(negedge clk);
        check("bp_pre_accept", 64'(bus.req_ready), 64'(2'b01));
        step();
        @(negedge clk);
        r0 = bus.resp_result;
        check("bp_valid", 64'(bus.resp_valid), 64'(2'b10));
        check("bp_result", 64'(r0), 64'(32'h0123_4500));
        check("bp_ce", 64'(mul_ce), 64'(0));
        check("bp_no_accept", 64'(bus.req_ready), 64'(0));
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            check("bp_hold_valid", 64'(bus.resp_valid), 64'(2'b10));
            check("bp_hold_result", 64'(bus.resp_result), 64'(r0));
            check("bp_hold_ce", 64'(mul_ce), 64'(0));
            check("bp_hold_ready", 64'(bus.req_ready), 64'(0));
        end
        step();
        bus.resp_ready = 2'b11;
        @(negedge clk);
        check("bp_release_ce", 64'(mul_ce), 64'(1));
        check("bp_release_accept", 64'(bus.req_ready), 64'(2'b01));
        step();
        bus.req_valid = 2'b00;
        drain();

        // Flush of port 1 with a port 0 op interleaved.
        step(); drive(1, $urandom, $urandom, 3'b000);
        step(); bus.req_valid = 2'b00; drive(0, 32'd5, 32'd6, 3'b000);
        step(); bus.req_valid = 2'b00; drive(1, $urandom, $urandom, 3'b011);
        step(); drive(1, $urandom, $urandom, 3'b001);
        step();
        bus.flush = 2'b10;
        drive(0, 32'd9, 32'd9, 3'b000);
        @(negedge clk);
        check("fl_retire_shown", 64'(bus.resp_valid[1]), 64'(1));
        check("fl_ce", 64'(mul_ce), 64'(1));
        check("fl_accept", 64'(bus.req_ready), 64'(2'b01));
        step();
        bus.flush     = 2'b00;
        bus.req_valid = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("fl_no_resp1", 64'(bus.resp_valid[1]), 64'(0));
        end
        drain();

        // Reset with four ops in flight; pointer left at port 1 beforehand.
        for (int k = 0; k < 3; k++) begin
            step();
            drive(0, $urandom, $urandom, 3'b000);
            drive(1, $urandom, $urandom, 3'b000);
            @(negedge clk);
            check("pre_rst_grant", 64'(bus.req_ready), 64'((k % 2) ? 2'b10 : 2'b01));
        end
        step();
        bus.req_valid = 2'b00;
        drive(1, $urandom, $urandom, 3'b000);
        step();
        bus.req_valid = 2'b00;
        reset_n       = 1'b0;
        @(negedge clk);
        check("mid_rst_resp", 64'(bus.resp_valid), 64'(0));
        check("mid_rst_idle", 64'(idle), 64'(1));
        check("mid_rst_ce", 64'(mul_ce), 64'(0));
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_resp", 64'(bus.resp_valid), 64'(0));
            check("post_rst_idle", 64'(idle), 64'(1));
        end
        step();
        drive(0, $urandom, $urandom, 3'b000);
        drive(1, $urandom, $urandom, 3'b000);
        @(negedge clk);
        check("post_rst_rr", 64'(bus.req_ready), 64'(2'b01));
        step();
        bus.req_valid = 2'b00;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
